// File: rtl/reload_timer_pkg.sv
// Shared types and constants for the auto-reload timer.
package reload_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/reload_timer_if.sv
// Control/status bundle of the auto-reload timer.
interface reload_timer_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
);

  logic                  start_i;
  logic                  stop_i;
  logic                  load_i;
  logic [WIDTH-1:0]      load_val_i;
  logic                  dir_i;
  logic                  oneshot_i;
  logic [PRESCALE_W-1:0] prescale_i;
  logic [WIDTH-1:0]      count_o;
  logic                  tc_o;
  logic                  running_o;
  logic                  done_o;

  modport master (
    output start_i, stop_i, load_i, load_val_i, dir_i, oneshot_i, prescale_i,
    input  count_o, tc_o, running_o, done_o
  );

  modport slave (
    input  start_i, stop_i, load_i, load_val_i, dir_i, oneshot_i, prescale_i,
    output count_o, tc_o, running_o, done_o
  );

endinterface

// File: rtl/reload_timer_prescaler.sv
// Clock-enable divider: tick_o is high one cycle in every prescale_i+1 while enabled.
module reload_timer_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  enable_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a lowered divisor fires at once instead of wrapping.
  assign tick_o = enable_i && !clear_i && (cnt_q >= prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !enable_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reload_timer.sv
// Parametrised auto-reload up/down timer with prescaler, one-shot mode and terminal-count pulse.
module reload_timer
  import reload_timer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  reload_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] AllOnes = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             running_q, done_q;
  logic             step;
  logic             pre_clear;
  logic             terminal;

  assign pre_clear = bus.load_i | bus.stop_i | bus.start_i;
  assign terminal  = (bus.dir_i == DIR_DOWN) ? (count_q == '0) : (count_q == AllOnes);

  reload_timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (pre_clear),
    .enable_i  (state_q == StRun),
    .prescale_i(bus.prescale_i),
    .tick_o    (step)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (bus.load_i) begin
      reload_d = bus.load_val_i;
      count_d  = bus.load_val_i;
      if (bus.stop_i) begin
        state_d = StIdle;
      end else if (bus.start_i) begin
        state_d = StRun;
      end
    end else if (bus.stop_i) begin
      state_d = StIdle;
    end else if (bus.start_i) begin
      count_d = reload_q;
      state_d = StRun;
    end else if (state_q == StRun && step) begin
      if (terminal) begin
        tc_d = 1'b1;
        if (bus.oneshot_i) begin
          state_d = StDone;
        end else begin
          count_d = reload_q;
        end
      end else if (bus.dir_i == DIR_DOWN) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
      running_q <= (state_d == StRun);
      done_q    <= (state_d == StDone);
    end
  end

  assign bus.count_o   = count_q;
  assign bus.tc_o      = tc_q;
  assign bus.running_o = running_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_reload_timer.sv
// Scoreboard bench for reload_timer: driver queues per-cycle expectations, monitor checks them.
module tb_reload_timer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reload_timer_if #(.WIDTH(8), .PRESCALE_W(4)) bus ();

  reload_timer #(
    .WIDTH(8),
    .PRESCALE_W(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [10:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input logic [10:0] act, input logic [10:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%h tc=%b run=%b done=%b, expected count=%h tc=%b run=%b done=%b",
               nm, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Queue what the outputs must be after the coming edge, then release pulse inputs.
  task automatic cyc(input logic [7:0] c, input logic tc, input logic run, input logic dn,
                     input string nm);
    exp_t e;
    e.val = {c, tc, run, dn};
    e.nm  = nm;
    sb.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.load_i  = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({bus.count_o, bus.tc_o, bus.running_o, bus.done_o}, mon_e.val, mon_e.nm);
    end
  end

  initial begin
    reset          = 1'b1;
    bus.start_i    = 1'b0;
    bus.stop_i     = 1'b0;
    bus.load_i     = 1'b0;
    bus.load_val_i = 8'h00;
    bus.dir_i      = 1'b0;
    bus.oneshot_i  = 1'b0;
    bus.prescale_i = 4'd0;
    #1;
    chk({bus.count_o, bus.tc_o, bus.running_o, bus.done_o}, 11'd0, "reset_state");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc(8'h00, 0, 0, 0, "idle_after_reset");

    // Up-count auto-reload from 0xFC, prescale 0: period 4.
    bus.load_i = 1'b1; bus.load_val_i = 8'hFC; bus.start_i = 1'b1;
    cyc(8'hFC, 0, 1, 0, "up_load_start");
    for (int r = 0; r < 2; r++) begin
      cyc(8'hFD, 0, 1, 0, "up_fd");
      cyc(8'hFE, 0, 1, 0, "up_fe");
      cyc(8'hFF, 0, 1, 0, "up_ff");
      cyc(8'hFC, 1, 1, 0, "up_reload_tc");
    end
    bus.stop_i = 1'b1;
    cyc(8'hFC, 0, 0, 0, "up_stop_hold");

    // Down one-shot from 3, prescale 2.
    bus.dir_i = 1'b1; bus.oneshot_i = 1'b1; bus.prescale_i = 4'd2;
    bus.load_i = 1'b1; bus.load_val_i = 8'h03;
    cyc(8'h03, 0, 0, 0, "os_load_idle");
    bus.start_i = 1'b1;
    cyc(8'h03, 0, 1, 0, "os_start");
    cyc(8'h03, 0, 1, 0, "os_3");
    cyc(8'h03, 0, 1, 0, "os_3");
    for (int v = 2; v >= 0; v--) begin
      for (int k = 0; k < 3; k++) cyc(8'(v), 0, 1, 0, "os_down");
    end
    cyc(8'h00, 1, 0, 1, "os_tc_done");
    cyc(8'h00, 0, 0, 1, "os_done_hold");
    cyc(8'h00, 0, 0, 1, "os_done_hold");
    bus.start_i = 1'b1;
    cyc(8'h03, 0, 1, 0, "os_restart");
    bus.stop_i = 1'b1;
    cyc(8'h03, 0, 0, 0, "os_stop");

    // Load + stop together while running.
    bus.dir_i = 1'b0; bus.oneshot_i = 1'b0; bus.prescale_i = 4'd0;
    bus.load_i = 1'b1; bus.load_val_i = 8'h20; bus.start_i = 1'b1;
    cyc(8'h20, 0, 1, 0, "ls_start");
    cyc(8'h21, 0, 1, 0, "ls_count");
    bus.load_i = 1'b1; bus.load_val_i = 8'h10; bus.stop_i = 1'b1;
    cyc(8'h10, 0, 0, 0, "ls_load_stop");
    cyc(8'h10, 0, 0, 0, "ls_idle_hold");
    bus.start_i = 1'b1;
    cyc(8'h10, 0, 1, 0, "ls_restart");
    cyc(8'h11, 0, 1, 0, "ls_count2");
    bus.stop_i = 1'b1;
    cyc(8'h11, 0, 0, 0, "ls_stop");

    // Prescale lowered 15 -> 2 with the prescaler at 9.
    bus.prescale_i = 4'd15;
    bus.load_i = 1'b1; bus.load_val_i = 8'h40; bus.start_i = 1'b1;
    cyc(8'h40, 0, 1, 0, "ps_start");
    for (int k = 0; k < 9; k++) cyc(8'h40, 0, 1, 0, "ps_wait15");
    bus.prescale_i = 4'd2;
    cyc(8'h41, 0, 1, 0, "ps_lower_step");
    cyc(8'h41, 0, 1, 0, "ps_41");
    cyc(8'h41, 0, 1, 0, "ps_41");
    cyc(8'h42, 0, 1, 0, "ps_42");
    cyc(8'h42, 0, 1, 0, "ps_42");
    cyc(8'h42, 0, 1, 0, "ps_42");
    cyc(8'h43, 0, 1, 0, "ps_43");
    bus.stop_i = 1'b1;
    cyc(8'h43, 0, 0, 0, "ps_stop");

    // Asynchronous reset mid-run at 0x80.
    bus.prescale_i = 4'd0;
    bus.load_i = 1'b1; bus.load_val_i = 8'h7E; bus.start_i = 1'b1;
    cyc(8'h7E, 0, 1, 0, "ar_start");
    cyc(8'h7F, 0, 1, 0, "ar_7f");
    cyc(8'h80, 0, 1, 0, "ar_80");
    reset = 1'b1;
    #1;
    chk({bus.count_o, bus.tc_o, bus.running_o, bus.done_o}, 11'd0, "async_reset_clear");
    @(negedge clk);
    reset = 1'b0;
    cyc(8'h00, 0, 0, 0, "post_reset_idle");
    cyc(8'h00, 0, 0, 0, "post_reset_idle");

    chk(11'(sb.size()), 11'd0, "scoreboard_drained");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
